// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP constant, reset PC
// and the buffered instruction payload type.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_DROP = ST_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
// master = fetch unit, slave = memory/pipeline environment.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;

  logic            instr_valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic [4:0]      opcode_o;
  logic [2:0]      func3_o;
  logic            func7_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  stall_i, redirect_i, redirect_pc_i,
    output instr_valid_o, instr_o, pc_o, opcode_o, func3_o, func7_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output stall_i, redirect_i, redirect_pc_i,
    input  instr_valid_o, instr_o, pc_o, opcode_o, func3_o, func7_o
  );

endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit with a one-entry output buffer,
// redirect handling and discard of responses belonging to a stale PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk_i,
  input  logic          cntrst_i,
  instr_fetch_if.master bus
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  fetch_entry_t    r_entry;

  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_valid_nxt;
  fetch_entry_t    w_entry_nxt;
  logic            w_buf_free;
  logic            w_req;
  logic            w_grant;

  // A request may only go out when the buffer is empty or drains this cycle.
  assign w_buf_free = !r_valid || !bus.stall_i;
  assign w_req      = (r_state == S_REQ) && w_buf_free;
  assign w_grant    = w_req && bus.imem_gnt_i;

  always_ff @(posedge clk_i or negedge cntrst_i) begin
    if (!cntrst_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_entry <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_entry <= w_entry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_entry_nxt = r_entry;

    if (r_valid && !bus.stall_i) w_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_grant) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          w_entry_nxt = '{pc: r_pc, instr: bus.imem_rdata_i};
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect wins over everything; a response still in flight must be dropped,
    // but one arriving this very cycle is already accounted for.
    if (bus.redirect_i) begin
      w_pc_nxt    = align_word(bus.redirect_pc_i);
      w_valid_nxt = 1'b0;
      w_entry_nxt = r_entry;
      case (r_state)
        S_REQ:          w_state_nxt = w_grant ? S_DROP : S_REQ;
        S_WAIT, S_DROP: w_state_nxt = bus.imem_rvalid_i ? S_REQ : S_DROP;
        default:        w_state_nxt = S_REQ;
      endcase
    end
  end

  assign bus.imem_req_o    = w_req;
  assign bus.imem_addr_o   = r_pc;
  assign bus.instr_valid_o = r_valid;
  assign bus.instr_o       = r_entry.instr;
  assign bus.pc_o          = r_entry.pc;
  assign bus.opcode_o      = r_entry.instr[6:2];
  assign bus.func3_o       = r_entry.instr[14:12];
  assign bus.func7_o       = r_entry.instr[30];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i    (clk),
    .cntrst_i (rst_n),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
  endtask

  // Leaves the caller at a falling edge with reset just released.
  task automatic do_reset();
    drive_idle();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total += 5;
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b exp 0", bus.imem_req_o); end
    if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", bus.instr_valid_o); end
    if (bus.instr_o !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr: got %h exp 00000013", bus.instr_o); end
    if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h exp 0", bus.pc_o); end
    if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h exp 0", bus.imem_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL idle_req: got %b exp 0", bus.imem_req_o); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.imem_gnt_i = 1'b1;
    @(negedge clk); #1;
    total += 2;
    if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL basic_req: got %b exp 1", bus.imem_req_o); end
    if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL basic_addr: got %h exp 0", bus.imem_addr_o); end
    @(negedge clk);
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0010_0093;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL basic_wait_req: got %b exp 0", bus.imem_req_o); end
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    #1;
    total += 8;
    if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b exp 1", bus.instr_valid_o); end
    if (bus.instr_o !== 32'h0010_0093) begin bad++; $display("FAIL basic_instr: got %h exp 00100093", bus.instr_o); end
    if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL basic_pc: got %h exp 0", bus.pc_o); end
    if (bus.opcode_o !== 5'b00100) begin bad++; $display("FAIL basic_opcode: got %b exp 00100", bus.opcode_o); end
    if (bus.func3_o !== 3'b000) begin bad++; $display("FAIL basic_func3: got %b exp 000", bus.func3_o); end
    if (bus.func7_o !== 1'b0) begin bad++; $display("FAIL basic_func7: got %b exp 0", bus.func7_o); end
    if (bus.imem_addr_o !== 32'h4) begin bad++; $display("FAIL basic_next_addr: got %h exp 4", bus.imem_addr_o); end
    if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL basic_next_req: got %b exp 1", bus.imem_req_o); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = $urandom;
    do_reset();
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = w;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    bus.stall_i = 1'b1;
    repeat (5) begin
      #1;
      total += 4;
      if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL stall_req: got %b exp 0", bus.imem_req_o); end
      if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b exp 1", bus.instr_valid_o); end
      if (bus.instr_o !== w) begin bad++; $display("FAIL stall_instr: got %h exp %h", bus.instr_o, w); end
      if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL stall_pc: got %h exp 0", bus.pc_o); end
      @(negedge clk);
    end
    bus.stall_i = 1'b0;
    #1;
    total += 2;
    if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL unstall_req: got %b exp 1", bus.imem_req_o); end
    if (bus.imem_addr_o !== 32'h4) begin bad++; $display("FAIL unstall_addr: got %h exp 4", bus.imem_addr_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0102;
    @(negedge clk);
    bus.redirect_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    total += 3;
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL drop_req: got %b exp 0", bus.imem_req_o); end
    if (bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL drop_addr: got %h exp 100", bus.imem_addr_o); end
    if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL drop_valid: got %b exp 0", bus.instr_valid_o); end
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    #1;
    total += 4;
    if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL drop_spurious: got %b exp 0", bus.instr_valid_o); end
    if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL redir_req: got %b exp 1", bus.imem_req_o); end
    if (bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL redir_addr: got %h exp 100", bus.imem_addr_o); end
    if (bus.instr_o !== 32'h0000_0013) begin bad++; $display("FAIL drop_instr: got %h exp 00000013", bus.instr_o); end
  endtask

  task automatic test_gnt_withheld();
    do_reset();
    @(negedge clk);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0045;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    repeat (3) begin
      #1;
      total += 2;
      if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL nognt_req: got %b exp 1", bus.imem_req_o); end
      if (bus.imem_addr_o !== 32'h44) begin bad++; $display("FAIL nognt_addr: got %h exp 44", bus.imem_addr_o); end
      @(negedge clk);
    end
    bus.imem_gnt_i = 1'b1;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL gnt_req: got %b exp 1", bus.imem_req_o); end
    @(negedge clk);
    bus.imem_gnt_i = 1'b0;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL after_gnt_req: got %b exp 0", bus.imem_req_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    w = $urandom;
    do_reset();
    @(negedge clk);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    #1;
    total++;
    if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h exp fffffffc", bus.imem_addr_o); end
    @(negedge clk);
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = w;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    #1;
    total += 3;
    if (bus.pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %h exp fffffffc", bus.pc_o); end
    if (bus.instr_o !== w) begin bad++; $display("FAIL wrap_instr: got %h exp %h", bus.instr_o, w); end
    if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next: got %h exp 0", bus.imem_addr_o); end
  endtask

  task automatic test_reset_midwait();
    logic [31:0] w;
    w = $urandom | 32'h8000_0000;
    do_reset();
    @(negedge clk);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = w;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    bus.imem_gnt_i    = 1'b1;
    #1;
    total++;
    if (bus.pc_o !== 32'h200) begin bad++; $display("FAIL mid_pc: got %h exp 200", bus.pc_o); end
    @(negedge clk);
    bus.imem_gnt_i = 1'b0;
    #1;
    total += 2;
    if (bus.imem_addr_o !== 32'h204) begin bad++; $display("FAIL mid_addr: got %h exp 204", bus.imem_addr_o); end
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL mid_wait_req: got %b exp 0", bus.imem_req_o); end
    #1 rst_n = 1'b0;
    #1;
    total += 4;
    if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL async_addr: got %h exp 0", bus.imem_addr_o); end
    if (bus.instr_o !== 32'h0000_0013) begin bad++; $display("FAIL async_instr: got %h exp 00000013", bus.instr_o); end
    if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL async_pc: got %h exp 0", bus.pc_o); end
    if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL async_req: got %b exp 0", bus.imem_req_o); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = $urandom;
    @(negedge clk);
    #1;
    total += 3;
    if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL late_valid0: got %b exp 0", bus.instr_valid_o); end
    if (bus.imem_req_o !== 1'b1) begin bad++; $display("FAIL late_req: got %b exp 1", bus.imem_req_o); end
    if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL late_addr: got %h exp 0", bus.imem_addr_o); end
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL late_valid1: got %b exp 0", bus.instr_valid_o); end
  endtask

  // Reference model: one fetch may be in flight; a redirect marks it stale.
  task automatic test_random();
    logic        m_started, m_out, m_stale, m_valid;
    logic [31:0] m_pc, m_instr, m_pco;
    logic        mem_pend, act_req, req_e;
    int          mem_cnt;
    logic        n_out, n_stale, n_valid;
    logic [31:0] n_pc, n_instr, n_pco;
    do_reset();
    m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_instr = 32'h13; m_pco = 32'h0;
    mem_pend = 1'b0; mem_cnt = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.stall_i       = ($urandom_range(0, 9) < 3);
      bus.redirect_i    = ($urandom_range(0, 19) == 0);
      bus.redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      bus.imem_gnt_i    = ($urandom_range(0, 9) < 6);
      bus.imem_rvalid_i = mem_pend && (mem_cnt == 0);
      bus.imem_rdata_i  = $urandom;
      #1;
      req_e = m_started && !m_out && (!m_valid || !bus.stall_i);
      act_req = bus.imem_req_o;
      total += 8;
      if (bus.imem_req_o !== req_e) begin bad++; $display("FAIL rnd_req c%0d: got %b exp %b", cyc, bus.imem_req_o, req_e); end
      if (bus.imem_addr_o !== m_pc) begin bad++; $display("FAIL rnd_addr c%0d: got %h exp %h", cyc, bus.imem_addr_o, m_pc); end
      if (bus.instr_valid_o !== m_valid) begin bad++; $display("FAIL rnd_valid c%0d: got %b exp %b", cyc, bus.instr_valid_o, m_valid); end
      if (bus.instr_o !== m_instr) begin bad++; $display("FAIL rnd_instr c%0d: got %h exp %h", cyc, bus.instr_o, m_instr); end
      if (bus.pc_o !== m_pco) begin bad++; $display("FAIL rnd_pc c%0d: got %h exp %h", cyc, bus.pc_o, m_pco); end
      if (bus.opcode_o !== m_instr[6:2]) begin bad++; $display("FAIL rnd_opcode c%0d: got %h exp %h", cyc, bus.opcode_o, m_instr[6:2]); end
      if (bus.func3_o !== m_instr[14:12]) begin bad++; $display("FAIL rnd_func3 c%0d: got %h exp %h", cyc, bus.func3_o, m_instr[14:12]); end
      if (bus.func7_o !== m_instr[30]) begin bad++; $display("FAIL rnd_func7 c%0d: got %b exp %b", cyc, bus.func7_o, m_instr[30]); end
      @(posedge clk);
      n_out = m_out; n_stale = m_stale; n_valid = m_valid;
      n_pc = m_pc; n_instr = m_instr; n_pco = m_pco;
      if (m_valid && !bus.stall_i) n_valid = 1'b0;
      if (m_out && bus.imem_rvalid_i) begin
        n_out = 1'b0;
        n_stale = 1'b0;
        if (!m_stale && !bus.redirect_i) begin
          n_valid = 1'b1; n_instr = bus.imem_rdata_i; n_pco = m_pc; n_pc = m_pc + 32'd4;
        end
      end
      if (req_e && bus.imem_gnt_i) begin
        n_out = 1'b1;
        n_stale = bus.redirect_i;
      end
      if (bus.redirect_i) begin
        n_pc = {bus.redirect_pc_i[31:2], 2'b00};
        n_valid = 1'b0;
        if (m_out && !bus.imem_rvalid_i) n_stale = 1'b1;
      end
      m_out = n_out; m_stale = n_stale; m_valid = n_valid;
      m_pc = n_pc; m_instr = n_instr; m_pco = n_pco; m_started = 1'b1;
      if (bus.imem_rvalid_i) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (act_req && bus.imem_gnt_i) begin
        mem_pend = 1'b1;
        mem_cnt = $urandom_range(0, 2);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_gnt_withheld();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 cntrst_i  in  1  reset, asynchronous, active-low.
REQ-004 imem_req_o  out  1  instruction memory request.
REQ-005 imem_addr_o  out  32  fetch address, word-aligned.
REQ-006 imem_gnt_i  in  1  request accepted this cycle.
REQ-007 imem_rvalid_i  in  1  read data valid, at least one cycle after grant.
REQ-008 imem_rdata_i  in  32  fetched instruction word.
REQ-009 stall_i  in  1  downstream decode/control not ready.
REQ-010 redirect_i  in  1  taken branch/JAL/JALR from execute.
REQ-011 redirect_pc_i  in  32  redirect target.
REQ-012 instr_valid_o  out  1  instr_o/pc_o hold a valid instruction.
REQ-013 instr_o  out  32  instruction word to control.
REQ-014 pc_o  out  32  address of instr_o.
REQ-015 opcode_o  out  5  instr_o[6:2]; func3_o  out  3  instr_o[14:12]; func7_o  out  1  instr_o[30].

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DROP.
REQ-017 IDLE: entered on reset; SHALL move to REQ on the first clock edge after reset release.
REQ-018 REQ: imem_req_o=1 only when the output buffer is free (instr_valid_o=0, or instr_valid_o=1 and stall_i=0); imem_gnt_i=1 with imem_req_o=1 -> WAIT.
REQ-019 imem_addr_o SHALL equal the fetch PC register at all times.
REQ-020 WAIT: imem_req_o=0; on imem_rvalid_i=1, instr_o<=imem_rdata_i, pc_o<=fetch PC, instr_valid_o<=1, fetch PC<=fetch PC+4 (mod 2^32), -> REQ.
REQ-021 At most one request SHALL be outstanding; peak throughput is one instruction per two cycles.
REQ-022 Consumption: instr_valid_o=1 and stall_i=0 at a clock edge retires the entry; instr_valid_o<=0 unless a new rvalid loads it in the same cycle.
REQ-023 While instr_valid_o=1 and stall_i=1, instr_o, pc_o, and instr_valid_o SHALL hold.
REQ-024 redirect_i=1 SHALL override all other events: fetch PC<={redirect_pc_i[31:2],2'b00}, instr_valid_o<=0.
REQ-025 Redirect in WAIT, or in REQ with grant the same cycle -> DROP; otherwise -> REQ with the new address.
REQ-026 DROP: imem_req_o=0; the next imem_rvalid_i SHALL be discarded, with no state update except ->REQ; a further redirect in DROP SHALL update the PC and remain in DROP.
REQ-027 opcode_o, func3_o, and func7_o SHALL be combinational slices of instr_o.

Reset
REQ-028 cntrst_i=0 SHALL immediately force: state IDLE, fetch PC=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the outstanding request; a late rvalid after reset release and before the first grant SHALL be ignored.

Structure
REQ-030 The shared core package SHALL hold the FSM state enum, the NOP constant, and the default RESET_PC.
REQ-031 Implementation SHALL be a single module, with no sub-modules.

Verification
REQ-032 Reset release with RESET_PC=0, gnt tied to 1, rvalid one cycle later, rdata=32'h0010_0093 -> req at cycle 1, addr 0; instr_valid_o at cycle 3; opcode_o=5'b00100, func3_o=0, func7_o=0; next addr=4.
REQ-033 stall_i=1 held 5 cycles with a valid entry -> no request issued; instr_o and pc_o stable; on stall release, request for the next PC in that cycle.
REQ-034 redirect_i=1 to 32'h0000_0102 while in WAIT -> DROP; the following rvalid is discarded; next request addr=32'h0000_0100; no spurious instr_valid_o.
REQ-035 imem_gnt_i withheld 3 cycles -> imem_req_o and imem_addr_o stable until grant.
REQ-036 Fetch PC=32'hFFFF_FFFC completes -> next addr=32'h0000_0000.
REQ-037 cntrst_i asserted during WAIT -> all outputs take reset values asynchronously; a late rvalid before the first grant is ignored.
